// File: rtl/sc_io_pkg.sv
// sc_io_pkg: shared constants for the memory-mapped I/O port block.
//   Register word indices, seven-segment patterns (active-low, segment g in
//   the MSB) and the reset value of the display output.
package sc_io_pkg;
  localparam logic [4:0] REG_SW   = 5'd0;
  localparam logic [4:0] REG_EDGE = 5'd1;
  localparam logic [4:0] REG_HEX  = 5'd2;
  localparam logic [4:0] REG_CTRL = 5'd3;
  localparam logic [4:0] REG_TICK = 5'd4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;
  // Indexed by nibble value; the leftmost entry is digit F.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  localparam logic [27:0] IO_OUT_RST = {4{SEG_ZERO}};
endpackage

// File: rtl/hex7seg.sv
// hex7seg: combinational hex-digit to active-low seven-segment decoder.
//   nibble  in  4  hex digit
//   seg     out 7  segments {g,f,e,d,c,b,a}, 0 = lit
module hex7seg
  import sc_io_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = SEG_TABLE[nibble];
endmodule

// File: rtl/sc_io_ports.sv
// sc_io_ports: memory-mapped switch/display/tick I/O block of the single-cycle computer.
//   clock        in  1   sole clock, rising edge
//   resetn       in  1   asynchronous active-low reset
//   addr         in  5   word index in the I/O window
//   datain       in  32  write data
//   we           in  1   write strobe
//   io_in        in  10  raw switches (asynchronous)
//   io_out       out 28  four active-low seven-segment digits, digit n at [7n+6:7n]
//   io_data_out  out 32  combinational read data for addr
module sc_io_ports
  import sc_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_DIV        = 50000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [4:0]  addr,
  input  logic [31:0] datain,
  input  logic        we,
  input  logic [9:0]  io_in,
  output logic [27:0] io_out,
  output logic [31:0] io_data_out
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  logic [9:0]    sync1, sync2, cand, sw, sw_next, edges;
  logic [CW-1:0] cnt;
  logic [15:0]   hex;
  logic          ctrl;
  logic [31:0]   tick;
  logic [PW-1:0] pre;
  logic [27:0]   seg;
  logic          wr_edge, wr_hex, wr_ctrl, wr_tick, wrap;
  assign wr_edge = we && addr == REG_EDGE;
  assign wr_hex  = we && addr == REG_HEX;
  assign wr_ctrl = we && addr == REG_CTRL;
  assign wr_tick = we && addr == REG_TICK;
  assign wrap    = pre == PRE_MAX;
  // The candidate becomes the stable value once it has matched the synchronised
  // input for DEBOUNCE_CYCLES further cycles; cnt then stays at CNT_MAX.
  assign sw_next = (sync2 == cand && cnt == CNT_MAX) ? cand : sw;
  for (genvar i = 0; i < 4; i++) begin : g_dig
    hex7seg u_dec (.nibble(hex[4*i +: 4]), .seg(seg[7*i +: 7]));
  end
  always_comb begin
    io_data_out = addr == REG_SW   ? {22'b0, sw}    :
                  addr == REG_EDGE ? {22'b0, edges} :
                  addr == REG_HEX  ? {16'b0, hex}   :
                  addr == REG_CTRL ? {31'b0, ctrl}  :
                  addr == REG_TICK ? tick           : 32'b0;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1  <= '0;
      sync2  <= '0;
      cand   <= '0;
      cnt    <= '0;
      sw     <= '0;
      edges  <= '0;
      hex    <= '0;
      ctrl   <= 1'b1;
      tick   <= '0;
      pre    <= '0;
      io_out <= IO_OUT_RST;
    end else begin
      sync1 <= io_in;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      sw <= sw_next;
      // Clear is applied before the OR so a simultaneous rising edge wins.
      edges <= (edges & ~(wr_edge ? datain[9:0] : 10'b0)) | (sw_next & ~sw);
      if (wr_hex) hex <= datain[15:0];
      if (wr_ctrl) ctrl <= datain[0];
      io_out <= ctrl ? seg : {4{SEG_BLANK}};
      if (wr_tick) begin
        tick <= datain;
        pre  <= '0;
      end else if (wrap) begin
        tick <= tick + 32'd1;
        pre  <= '0;
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sc_io_ports.sv
// tb_sc_io_ports: directed and randomized checks of sc_io_ports against a behavioural model.
module tb_sc_io_ports;
  localparam int D  = 3;
  localparam int TD = 4;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  logic        clock = 0;
  logic        resetn = 0;
  logic        we = 0;
  logic [4:0]  addr = 0;
  logic [31:0] datain = 0;
  logic [9:0]  io_in = 0;
  logic [27:0] io_out;
  logic [31:0] io_data_out;
  int n_checks = 0;
  int n_fail = 0;
  logic [9:0]  m_sw, m_edge;
  logic [15:0] m_hex;
  logic        m_ctrl;
  logic [31:0] t_base;
  int          t_edges;
  logic [27:0] m_out;
  logic [9:0]  hist[$];

  sc_io_ports #(.DEBOUNCE_CYCLES(D), .TICK_DIV(TD)) dut (
    .clock(clock), .resetn(resetn), .addr(addr), .datain(datain), .we(we),
    .io_in(io_in), .io_out(io_out), .io_data_out(io_data_out)
  );

  always #10 clock = ~clock;

  function automatic logic [27:0] disp(logic [15:0] h, logic en);
    logic [27:0] r;
    for (int n = 0; n < 4; n++) r[7*n +: 7] = en ? SEG_TAB[h[4*n +: 4]] : 7'h7F;
    return r;
  endfunction

  function automatic logic [31:0] exp_rd(int a);
    case (a)
      0: return {22'b0, m_sw};
      1: return {22'b0, m_edge};
      2: return {16'b0, m_hex};
      3: return {31'b0, m_ctrl};
      4: return t_base + 32'(t_edges / TD);
      default: return 32'b0;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic mreset();
    m_sw = 0; m_edge = 0; m_hex = 0; m_ctrl = 1;
    t_base = 0; t_edges = 0;
    m_out = 28'h8102040;
    hist.delete();
    for (int i = 0; i < D + 3; i++) hist.push_back(10'b0);
  endtask

  // One rising edge, with the model advanced by the same edge; returns 1 ns after it.
  task automatic clk_step();
    logic [27:0] out_n;
    logic [9:0]  nsw;
    bit same;
    out_n = disp(m_hex, m_ctrl);
    @(posedge clock);
    hist.push_back(io_in);
    // A value is accepted once D+1 consecutive synchronised samples agree;
    // the synchroniser delays each sample by two edges.
    same = 1;
    for (int i = 0; i <= D; i++) if (hist[hist.size()-3-i] !== hist[hist.size()-3]) same = 0;
    nsw = same ? hist[hist.size()-3] : m_sw;
    if (we && addr == 1) m_edge &= ~datain[9:0];
    if (we && addr == 2) m_hex = datain[15:0];
    if (we && addr == 3) m_ctrl = datain[0];
    if (we && addr == 4) begin
      t_base = datain;
      t_edges = 0;
    end else begin
      t_edges++;
    end
    m_edge |= nsw & ~m_sw;
    m_sw = nsw;
    m_out = out_n;
    while (hist.size() > D + 3) void'(hist.pop_front());
    #1;
  endtask

  task automatic wr(logic [4:0] a, logic [31:0] d);
    we = 1; addr = a; datain = d;
    clk_step();
    we = 0;
  endtask

  task automatic expect_rd(string tag, logic [4:0] a, logic [31:0] exp);
    addr = a;
    #1;
    check(tag, io_data_out, exp);
  endtask

  task automatic check_all();
    for (int a = 0; a < 8; a++) expect_rd($sformatf("model_rd%0d", a), 5'(a), exp_rd(a));
    check("model_io_out", {4'b0, io_out}, {4'b0, m_out});
  endtask

  initial begin
    mreset();
    #25;
    resetn = 1;
    check("rst_io_out", {4'b0, io_out}, 32'h08102040);
    expect_rd("rst_ctrl", 5'd3, 32'd1);
    expect_rd("rst_sw", 5'd0, 32'd0);
    clk_step();
    check_all();
    expect_rd("rst_edge", 5'd1, 32'd0);
    expect_rd("rst_hex", 5'd2, 32'd0);
    expect_rd("rst_tick", 5'd4, 32'd0);
    expect_rd("rst_unmapped", 5'd7, 32'd0);
    // Display path
    wr(5'd2, 32'h0000BEEF);
    check("hex_io_out_early", {4'b0, io_out}, 32'h08102040);
    clk_step();
    check("hex_io_out", {4'b0, io_out}, {4'b0, 7'h03, 7'h06, 7'h06, 7'h0E});
    wr(5'd3, 32'h0);
    clk_step();
    check("blank_io_out", {4'b0, io_out}, 32'h0FFFFFFF);
    check_all();
    wr(5'd3, 32'h1);
    clk_step();
    check_all();
    // Debounce latency
    io_in = 10'h201;
    for (int k = 1; k <= 7; k++) begin
      clk_step();
      expect_rd("sw_latency", 5'd0, k >= 6 ? 32'h201 : 32'h0);
    end
    expect_rd("edge_set", 5'd1, 32'h201);
    wr(5'd1, 32'h1);
    expect_rd("edge_w1c", 5'd1, 32'h200);
    // Glitch rejection
    io_in = 10'h211;
    clk_step();
    clk_step();
    io_in = 10'h201;
    for (int k = 0; k < 8; k++) clk_step();
    expect_rd("glitch_sw", 5'd0, 32'h201);
    expect_rd("glitch_edge", 5'd1, 32'h200);
    clk_step();
    check_all();
    // Tick counter
    wr(5'd4, 32'h0);
    for (int k = 0; k < 40; k++) clk_step();
    expect_rd("tick_40", 5'd4, 32'd10);
    wr(5'd4, 32'hFFFFFFFF);
    for (int k = 0; k < 3; k++) clk_step();
    expect_rd("tick_hold", 5'd4, 32'hFFFFFFFF);
    clk_step();
    expect_rd("tick_roll", 5'd4, 32'h0);
    for (int k = 0; k < 3; k++) clk_step();
    wr(5'd4, 32'h1234);
    for (int k = 0; k < 3; k++) begin
      clk_step();
      expect_rd("tick_wrap_write", 5'd4, 32'h1234);
    end
    clk_step();
    expect_rd("tick_after_wrap_write", 5'd4, 32'h1235);
    check_all();
    // Randomized traffic
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(5) == 0) io_in = 10'($urandom);
      else if ($urandom_range(7) == 0) io_in ^= 10'(1 << $urandom_range(9));
      if ($urandom_range(3) == 0) begin
        we = 1;
        addr = 5'($urandom_range(7));
        datain = $urandom;
      end
      clk_step();
      we = 0;
      check_all();
    end
    // Asynchronous reset during debounce
    io_in = 10'h3FF;
    for (int k = 0; k < 3; k++) clk_step();
    #3;
    resetn = 0;
    io_in = 10'h0;
    mreset();
    expect_rd("async_rst_sw", 5'd0, 32'h0);
    check("async_rst_io_out", {4'b0, io_out}, 32'h08102040);
    #1;
    resetn = 1;
    for (int k = 0; k < 8; k++) clk_step();
    expect_rd("post_rst_sw", 5'd0, 32'h0);
    expect_rd("post_rst_edge", 5'd1, 32'h0);
    clk_step();
    check_all();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
